mul_seq_recon: RTL and testbench

//  Sequential radix-2 shift-add multiplier. Reconstructs the dividend from a

---
 rtl/mul_div_pkg.sv | 12 +
 rtl/mul_seq_add.sv | 13 +
 rtl/mul_seq_recon.sv | 99 +++++++++
 tb/tb_mul_seq_recon.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mul_div_pkg.sv
// Shared types and sizes for the multiply/divide arithmetic unit.
// Both the divider and the reconstruction multiplier import this.
package mul_div_pkg;
  localparam int WIDTH = 32;
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;
endpackage

// File: rtl/mul_seq_add.sv
// Double-width unsigned adder for the shift-add datapath.
// The product cannot overflow, so no carry-out is kept.
import mul_div_pkg::*;

module mul_seq_add #(
  parameter int N = PW
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum
);
  assign sum = a + b;
endmodule

// File: rtl/mul_seq_recon.sv
// Sequential radix-2 shift-add multiplier: p_out = q*b + r.
// Rebuilds the dividend from a divide result or does plain multiply.
import mul_div_pkg::*;

module mul_seq_recon #(
  parameter int WIDTH = mul_div_pkg::WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     q_in,
  input  logic [WIDTH-1:0]     b_in,
  input  logic [WIDTH-1:0]     r_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p_out,
  output logic                 busy
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t          state;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   mcand;
  logic [WIDTH-1:0] mplr;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   sum;
  logic [PW-1:0]   acc_nxt;

  mul_seq_add #(.N(PW)) u_add (
    .a   (acc),
    .b   (mcand),
    .sum (sum)
  );

  assign acc_nxt = mplr[0] ? sum : acc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplr      <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      p_out     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            acc      <= {{WIDTH{1'b0}}, r_in};
            mcand    <= {{WIDTH{1'b0}}, b_in};
            mplr     <= q_in;
            cnt      <= '0;
            state    <= ST_RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_RUN: begin
          acc   <= acc_nxt;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          // Fixed step count; cnt parks at LAST instead of wrapping.
          if (cnt == LAST) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            p_out     <= acc_nxt;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          acc       <= '0;
          mcand     <= '0;
          mplr      <= '0;
          cnt       <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          p_out     <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mul_seq_recon.sv
// Scoreboard bench for mul_seq_recon: driver pushes expected results,
// a negedge monitor checks latency, hold-under-stall and retired values.
module tb_mul_seq_recon;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  q_in, b_in, r_in;
  logic          out_valid;
  logic          out_ready;
  logic [2*W-1:0] p_out;
  logic          busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [2*W-1:0] exp_q[$];
  int             acc_q[$];
  logic           prev_ov = 1'b0;
  logic           prev_or = 1'b0;
  logic [2*W-1:0] prev_p = '0;

  mul_seq_recon dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q_in      (q_in),
    .b_in      (b_in),
    .r_in      (r_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p_out     (p_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [2*W-1:0] act,
                     input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) acc_q.push_back(cyc + 1);
      if (out_valid && !prev_ov) begin
        if (acc_q.size() == 0) fail_now("spurious_out_valid");
        else chk("latency", 64'(cyc - acc_q.pop_front()), 64'd32);
      end
      if (out_valid && prev_ov && !prev_or) begin
        chk("hold_p_out", p_out, prev_p);
        chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_result");
        else chk("p_out", p_out, exp_q.pop_front());
      end
    end
    prev_ov <= out_valid;
    prev_or <= out_ready;
    prev_p  <= p_out;
  end

  // Caller is aligned at posedge+1; returns at posedge+1 after accept.
  task automatic issue(input logic [W-1:0] q, input logic [W-1:0] b,
                       input logic [W-1:0] r, input logic [2*W-1:0] exp);
    int n;
    exp_q.push_back(exp);
    q_in = q;
    b_in = b;
    r_in = r;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) fail_now("accept_timeout");
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) fail_now("drain_timeout");
  endtask

  initial begin
    logic [W-1:0] a, b;
    int n;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    q_in = '0;
    b_in = '0;
    r_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_p_out", p_out, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(32'd7, 32'd6, 32'd5, 64'd47);
    drain();
    issue('1, '1, '1, 64'hFFFF_FFFF_0000_0000);
    drain();
    issue(32'd142, 32'd7, 32'd6, 64'd1000);
    drain();
    issue(32'd0, 32'd123, 32'd77, 64'd77);
    drain();
    issue(32'd99, 32'd0, 32'd5, 64'd5);
    drain();

    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      b = $urandom_range(32'hFFFF, 1);
      if (i % 2 == 1) b = $urandom | 32'h1;
      issue(a / b, b, a % b, {32'd0, a});
    end
    drain();

    // Backpressure, with new operands offered during the stall
    out_ready = 1'b0;
    issue(32'h1234, 32'h10, 32'd3, 64'h12343);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) fail_now("out_valid_timeout");
    for (int i = 0; i < 5; i++) begin
      q_in = 32'd2;
      b_in = 32'd9;
      r_in = 32'd1;
      in_valid = ~in_valid;
      @(posedge clk); #1;
    end
    chk("bp_busy", {63'd0, busy}, 64'd1);
    out_ready = 1'b1;
    issue(32'd2, 32'd9, 32'd1, 64'd19);
    drain();

    // Reset during RUN abandons the operation
    issue(32'd5, 32'd5, 32'd5, 64'd30);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    acc_q.delete();
    chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
    chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    repeat (40) @(posedge clk);
    #1;
    issue(32'd3, 32'd4, 32'd0, 64'd12);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
